// File: rtl/bus_reg_file_if.sv
// Internal byte-bus bundle between the UART bridge (master) and register-file slaves.
interface bus_reg_file_if;
  logic [15:0] int_address;
  logic [7:0]  int_wr_data;
  logic        int_write;
  logic        int_read;
  logic [7:0]  int_rd_data;
  logic        int_req;
  logic        int_gnt;

  modport master (
    output int_address, int_wr_data, int_write, int_read, int_req,
    input  int_rd_data, int_gnt
  );

  modport slave (
    input  int_address, int_wr_data, int_write, int_read, int_req,
    output int_rd_data, int_gnt
  );
endinterface

// File: rtl/bus_reg_file.sv
// Byte-bus register file: grant FSM, 16-byte window of ctrl/status/scratch/ID
// registers and a local-push / bus-pop byte FIFO.
module bus_reg_file #(
  parameter logic [15:0] BASE_ADDR  = 16'h0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [7:0]  ID_VALUE   = 8'hA5
) (
  input  logic                 clock,
  input  logic                 reset,
  bus_reg_file_if.slave        bus,
  input  logic                 local_lock,
  output logic [63:0]          ctrl_regs,
  input  logic [31:0]          status_in,
  input  logic [7:0]           fifo_wr_data,
  input  logic                 fifo_wr,
  output logic                 fifo_full
);
  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANTED = 1'b1} state_t;

  state_t         state_r;
  logic           gnt_r;
  logic [7:0]     rd_data_r;
  logic [63:0]    ctrl_r;
  logic [7:0]     scratch_r;
  logic [7:0]     mem_r [FIFO_DEPTH];
  logic [AW-1:0]  wptr_r;
  logic [AW-1:0]  rptr_r;
  logic [4:0]     count_r;
  logic           full_r;
  logic           ovf_r;
  logic           unf_r;

  logic [3:0]     offset_s;
  logic           hit_s;
  logic           wr_q_s;
  logic           rd_q_s;
  logic           pop_req_s;
  logic           pop_ok_s;
  logic           push_ok_s;
  logic           clr_sticky_s;
  logic [4:0]     count_next_s;
  logic [7:0]     rd_mux_s;

  assign offset_s         = bus.int_address[3:0];
  assign bus.int_gnt      = gnt_r;
  assign bus.int_rd_data  = rd_data_r;
  assign ctrl_regs        = ctrl_r;
  assign fifo_full        = full_r;

  // Access qualification and FIFO push/pop arbitration against pre-cycle state.
  always_comb begin
    hit_s        = 1'b0;
    wr_q_s       = 1'b0;
    rd_q_s       = 1'b0;
    pop_req_s    = 1'b0;
    pop_ok_s     = 1'b0;
    push_ok_s    = 1'b0;
    clr_sticky_s = 1'b0;
    if (gnt_r && (bus.int_address[15:4] == BASE_ADDR[15:4])) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
    wr_q_s       = hit_s && bus.int_write;
    rd_q_s       = hit_s && bus.int_read && !bus.int_write;
    pop_req_s    = rd_q_s && (offset_s == 4'hC);
    pop_ok_s     = pop_req_s && (count_r != 5'd0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    push_ok_s    = fifo_wr && ((count_r != DEPTH_C) || pop_ok_s);
    clr_sticky_s = wr_q_s && (offset_s == 4'hD);
    count_next_s = count_r + {4'b0000, push_ok_s} - {4'b0000, pop_ok_s};
  end

  // Read-data mux over the register window.
  always_comb begin
    rd_mux_s = 8'h00;
    case (offset_s)
      4'h0, 4'h1, 4'h2, 4'h3,
      4'h4, 4'h5, 4'h6, 4'h7: rd_mux_s = ctrl_r[{offset_s[2:0], 3'b000} +: 8];
      4'h8, 4'h9, 4'hA, 4'hB: rd_mux_s = status_in[{offset_s[1:0], 3'b000} +: 8];
      4'hC: begin
        if (pop_ok_s) begin
          rd_mux_s = mem_r[rptr_r];
        end else begin
          rd_mux_s = 8'h00;
        end
      end
      4'hD:    rd_mux_s = {ovf_r, unf_r, 1'b0, count_r};
      4'hE:    rd_mux_s = scratch_r;
      4'hF:    rd_mux_s = ID_VALUE;
      default: rd_mux_s = 8'h00;
    endcase
  end

  // Grant FSM; no preemption once granted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      gnt_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.int_req && !local_lock) begin
            state_r <= GRANTED;
            gnt_r   <= 1'b1;
          end
        end
        GRANTED: begin
          if (!bus.int_req) begin
            state_r <= IDLE;
            gnt_r   <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= 1'b0;
        end
      endcase
    end
  end

  // Register writes, read-data capture, FIFO pointers and sticky flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data_r <= 8'h00;
      ctrl_r    <= 64'h0;
      scratch_r <= 8'h00;
      wptr_r    <= '0;
      rptr_r    <= '0;
      count_r   <= 5'd0;
      full_r    <= 1'b0;
      ovf_r     <= 1'b0;
      unf_r     <= 1'b0;
    end else begin
      if (wr_q_s) begin
        case (offset_s)
          4'h0, 4'h1, 4'h2, 4'h3,
          4'h4, 4'h5, 4'h6, 4'h7: ctrl_r[{offset_s[2:0], 3'b000} +: 8] <= bus.int_wr_data;
          4'hE:    scratch_r <= bus.int_wr_data;
          default: ;
        endcase
      end
      if (rd_q_s) begin
        rd_data_r <= rd_mux_s;
      end
      if (push_ok_s) begin
        wptr_r <= wptr_r + 1'b1;
      end
      if (pop_ok_s) begin
        rptr_r <= rptr_r + 1'b1;
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == DEPTH_C);
      // A fresh event in the clearing cycle is kept rather than lost.
      ovf_r   <= (ovf_r && !clr_sticky_s) || (fifo_wr && !push_ok_s);
      unf_r   <= (unf_r && !clr_sticky_s) || (pop_req_s && !pop_ok_s);
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_r[wptr_r] <= fifo_wr_data;
    end
  end
endmodule

// File: tb/tb_bus_reg_file.sv
// Directed bench for bus_reg_file: read data checked through a scoreboard queue,
// grant/ctrl/full/reset behaviour checked directly.
module tb_bus_reg_file;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        local_lock = 1'b0;
  logic [63:0] ctrl_regs;
  logic [31:0] status_in = 32'hDEAD_BEEF;
  logic [7:0]  fifo_wr_data = 8'h00;
  logic        fifo_wr = 1'b0;
  logic        fifo_full;

  int checks = 0;
  int errors = 0;

  bus_reg_file_if bus ();

  bus_reg_file #(.BASE_ADDR(16'h0000), .FIFO_DEPTH(8), .ID_VALUE(8'hA5)) dut (
    .clock(clock), .reset(reset), .bus(bus), .local_lock(local_lock),
    .ctrl_regs(ctrl_regs), .status_in(status_in),
    .fifo_wr_data(fifo_wr_data), .fifo_wr(fifo_wr), .fifo_full(fifo_full)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  logic    exp_fire = 1'b0;
  logic    fire_d = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset) fire_d <= 1'b0;
    else        fire_d <= exp_fire;
  end

  // Monitor: int_rd_data is valid the cycle after each expected-qualified read.
  always @(negedge clock) begin
    if (fire_d) begin
      rd_exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s: read data 0x%02h with no expected entry", "scoreboard", bus.int_rd_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.int_rd_data !== e.exp) begin
          errors++;
          $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, bus.int_rd_data, e.exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    bus.int_address = a;
    bus.int_wr_data = d;
    bus.int_write   = 1'b1;
    @(negedge clock);
    bus.int_write   = 1'b0;
  endtask

  task automatic bus_rd(input string name, input logic [15:0] a, input logic [7:0] exp);
    rd_exp_t e;
    e.name = name;
    e.exp  = exp;
    exp_q.push_back(e);
    bus.int_address = a;
    bus.int_read    = 1'b1;
    exp_fire        = 1'b1;
    @(negedge clock);
    bus.int_read    = 1'b0;
    exp_fire        = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    fifo_wr_data = d;
    fifo_wr      = 1'b1;
    @(negedge clock);
    fifo_wr      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    bus.int_address = 16'h0000;
    bus.int_wr_data = 8'h00;
    bus.int_write   = 1'b0;
    bus.int_read    = 1'b0;
    bus.int_req     = 1'b0;
    cyc(2);
    chk("reset_gnt", {63'h0, bus.int_gnt}, 64'h0);
    chk("reset_rd_data", {56'h0, bus.int_rd_data}, 64'h0);
    chk("reset_ctrl", ctrl_regs, 64'h0);
    chk("reset_full", {63'h0, fifo_full}, 64'h0);
    reset = 1'b1;
    cyc(1);

    // 1: grant, ctrl write/read, ID
    bus.int_req = 1'b1;
    cyc(1);
    chk("gnt_rise", {63'h0, bus.int_gnt}, 64'h1);
    bus_wr(16'h0002, 8'h3C);
    chk("ctrl_byte2", {56'h0, ctrl_regs[23:16]}, 64'h3C);
    bus_rd("rd_ctrl2", 16'h0002, 8'h3C);
    bus_rd("rd_id", 16'h000F, 8'hA5);
    bus_wr(16'h000E, 8'h5A);
    bus_rd("rd_scratch", 16'h000E, 8'h5A);
    bus_rd("rd_status1", 16'h0009, 8'hBE);
    // write wins over a simultaneous read; rd_data must hold
    bus.int_read = 1'b1;
    bus_wr(16'h0004, 8'h44);
    bus.int_read = 1'b0;
    chk("wr_wins_ctrl4", {56'h0, ctrl_regs[39:32]}, 64'h44);
    chk("wr_wins_rd_hold", {56'h0, bus.int_rd_data}, 64'hBE);
    // out-of-window write ignored
    bus_wr(16'h0010, 8'h99);
    chk("out_of_window", {56'h0, ctrl_regs[7:0]}, 64'h0);

    // 2: local_lock blocks grant, no preemption
    bus.int_req = 1'b0;
    cyc(1);
    chk("gnt_fall", {63'h0, bus.int_gnt}, 64'h0);
    local_lock  = 1'b1;
    bus.int_req = 1'b1;
    cyc(2);
    chk("lock_blocks_gnt", {63'h0, bus.int_gnt}, 64'h0);
    bus_wr(16'h0000, 8'h77);
    chk("lock_wr_ignored", {56'h0, ctrl_regs[7:0]}, 64'h0);
    bus.int_address = 16'h000F;
    bus.int_read    = 1'b1;
    cyc(1);
    bus.int_read    = 1'b0;
    chk("unqual_rd_hold", {56'h0, bus.int_rd_data}, 64'hBE);
    local_lock = 1'b0;
    cyc(1);
    chk("gnt_after_unlock", {63'h0, bus.int_gnt}, 64'h1);
    local_lock = 1'b1;
    cyc(3);
    chk("no_preempt", {63'h0, bus.int_gnt}, 64'h1);
    bus.int_req = 1'b0;
    cyc(1);
    chk("gnt_drop", {63'h0, bus.int_gnt}, 64'h0);
    local_lock  = 1'b0;
    bus.int_req = 1'b1;
    cyc(1);

    // 3: basic FIFO and underflow sticky
    push(8'h11);
    push(8'h22);
    push(8'h33);
    bus_rd("stat_3", 16'h000D, 8'h03);
    bus_rd("pop_11", 16'h000C, 8'h11);
    bus_rd("pop_22", 16'h000C, 8'h22);
    bus_rd("pop_33", 16'h000C, 8'h33);
    bus_rd("pop_empty", 16'h000C, 8'h00);
    bus_rd("stat_unf", 16'h000D, 8'h40);
    bus_wr(16'h000D, 8'h00);
    bus_rd("stat_clr", 16'h000D, 8'h00);

    // 4: overflow
    for (int i = 1; i <= 9; i++) begin
      if (i == 9) chk("full_after_8", {63'h0, fifo_full}, 64'h1);
      v = 8'(i);
      push(v);
    end
    chk("full_after_9", {63'h0, fifo_full}, 64'h1);
    bus_rd("stat_ovf", 16'h000D, 8'h88);
    for (int i = 1; i <= 8; i++) begin
      v = 8'(i);
      bus_rd("pop_ovf_seq", 16'h000C, v);
    end
    chk("not_full", {63'h0, fifo_full}, 64'h0);
    bus_rd("stat_ovf_empty", 16'h000D, 8'h80);
    bus_wr(16'h000D, 8'hFF);

    // 5: simultaneous push/pop at full and at empty
    for (int i = 0; i < 8; i++) begin
      v = 8'hB0 + 8'(i);
      push(v);
    end
    fifo_wr_data = 8'hAA;
    fifo_wr      = 1'b1;
    bus_rd("pop_full_sim", 16'h000C, 8'hB0);
    fifo_wr      = 1'b0;
    bus_rd("stat_full_sim", 16'h000D, 8'h08);
    for (int i = 1; i < 8; i++) begin
      v = 8'hB0 + 8'(i);
      bus_rd("pop_b_seq", 16'h000C, v);
    end
    bus_rd("pop_aa_last", 16'h000C, 8'hAA);
    fifo_wr_data = 8'h55;
    fifo_wr      = 1'b1;
    bus_rd("pop_empty_sim", 16'h000C, 8'h00);
    fifo_wr      = 1'b0;
    bus_rd("stat_empty_sim", 16'h000D, 8'h41);
    bus_rd("pop_55", 16'h000C, 8'h55);

    // 6: asynchronous reset mid-grant
    bus_wr(16'h0003, 8'hFF);
    for (int i = 0; i < 5; i++) push(8'hC0);
    bus_rd("rd_ctrl3", 16'h0003, 8'hFF);
    bus_rd("stat_5", 16'h000D, 8'h45);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_gnt", {63'h0, bus.int_gnt}, 64'h0);
    chk("arst_ctrl", ctrl_regs, 64'h0);
    chk("arst_rd_data", {56'h0, bus.int_rd_data}, 64'h0);
    chk("arst_full", {63'h0, fifo_full}, 64'h0);
    @(negedge clock);
    reset = 1'b1;
    cyc(1);
    chk("regrant", {63'h0, bus.int_gnt}, 64'h1);
    bus_rd("stat_after_rst", 16'h000D, 8'h00);
    bus_rd("scratch_after_rst", 16'h000E, 8'h00);

    cyc(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected reads never observed", "drain", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
